// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller and the datapath muxes it steers:
// state codes, opcodes, mux-select constants and the strobe bundle.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_RALU = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_ANDI = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_SW   = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_CALL = 4'd8;
  localparam logic [3:0] OP_RET  = 4'd9;

  localparam logic [1:0] PC_SRC_PLUS2  = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_B_REG = 2'b00;
  localparam logic [1:0] ALU_B_TWO = 2'b01;
  localparam logic [1:0] ALU_B_IMM = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC2 = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  typedef struct packed {
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_src_b;
    logic [1:0] wb_sel;
    logic [1:0] alu_op;
  } ctrl_t;

  // All strobes low, all selects at their 00 setting.
  localparam ctrl_t CTRL_IDLE = ctrl_t'(13'd0);

  // Opcodes 10..15 have no defined behaviour and send the core to HALT.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_RET);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode: maps (state, opcode, zero, mem_ready) to the
// datapath control bundle. Holds no state; sequencing lives in multicycle_ctrl.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [3:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  // Per-state strobe table; anything not listed stays at the idle value.
  always_comb begin
    o_ctrl = CTRL_IDLE;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = ALU_B_TWO;
        if (i_mem_ready) begin
          o_ctrl.ir_write = 1'b1;
          o_ctrl.pc_write = 1'b1;
          o_ctrl.pc_src   = PC_SRC_PLUS2;
        end else begin
          o_ctrl.ir_write = 1'b0;
          o_ctrl.pc_write = 1'b0;
        end
      end
      ST_DECODE: begin
        case (i_opcode)
          OP_JMP, OP_RET: begin
            o_ctrl.pc_write = 1'b1;
            o_ctrl.pc_src   = PC_SRC_JUMP;
          end
          OP_CALL: begin
            o_ctrl.pc_write  = 1'b1;
            o_ctrl.pc_src    = PC_SRC_JUMP;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.wb_sel    = WB_PC2;
          end
          default: o_ctrl = CTRL_IDLE;
        endcase
      end
      ST_EXEC: begin
        case (i_opcode)
          OP_RALU: begin
            o_ctrl.alu_op    = ALU_FUNC;
            o_ctrl.alu_src_b = ALU_B_REG;
          end
          OP_ADDI: o_ctrl.alu_src_b = ALU_B_IMM;
          OP_ANDI: begin
            o_ctrl.alu_src_b = ALU_B_IMM;
            o_ctrl.alu_op    = ALU_FUNC;
          end
          OP_LW, OP_SW: begin
            o_ctrl.alu_src_b = ALU_B_IMM;
            o_ctrl.alu_op    = ALU_ADD;
          end
          OP_BEQ: begin
            o_ctrl.alu_op   = ALU_SUB;
            o_ctrl.pc_src   = PC_SRC_BRANCH;
            o_ctrl.pc_write = i_zero;
          end
          OP_BNE: begin
            o_ctrl.alu_op   = ALU_SUB;
            o_ctrl.pc_src   = PC_SRC_BRANCH;
            o_ctrl.pc_write = ~i_zero;
          end
          default: o_ctrl = CTRL_IDLE;
        endcase
      end
      ST_MEM: begin
        case (i_opcode)
          OP_LW:   o_ctrl.mem_read  = 1'b1;
          // Store only strobes in the cycle memory accepts it.
          OP_SW:   o_ctrl.mem_write = i_mem_ready;
          default: o_ctrl = CTRL_IDLE;
        endcase
      end
      ST_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.wb_sel    = (i_opcode == OP_LW) ? WB_MEM : WB_ALU;
      end
      default: o_ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencing, memory
// wait watchdog, sticky halt/timeout flags and a retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  pc_src,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        halted,
  output logic        mem_timeout,
  output logic [15:0] retired
);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_wait;
  logic        r_halted;
  logic        r_timeout;
  logic [15:0] r_retired;
  logic        w_stall;
  logic        w_wait_hit;
  logic        w_retire;
  ctrl_t       w_ctrl;
  ctrl_t       w_ctrl_gated;

  ctrl_decode u_decode (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_zero      (zero),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Watchdog: a memory stall that would bring the wait count up to the limit.
  always_comb begin
    w_stall    = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;
    w_wait_hit = w_stall && (({28'd0, r_wait} + 32'd1) >= MEM_WAIT_MAX);
  end

  // Next-state selection; unknown opcodes or state codes fall into HALT.
  always_comb begin
    w_next_state = ST_HALT;
    case (r_state)
      ST_FETCH: begin
        if (mem_ready)       w_next_state = ST_DECODE;
        else if (w_wait_hit) w_next_state = ST_HALT;
        else                 w_next_state = ST_FETCH;
      end
      ST_DECODE: begin
        case (opcode)
          OP_JMP, OP_RET, OP_CALL: w_next_state = ST_FETCH;
          default: w_next_state = op_is_legal(opcode) ? ST_EXEC : ST_HALT;
        endcase
      end
      ST_EXEC: begin
        case (opcode)
          OP_RALU, OP_ADDI, OP_ANDI: w_next_state = ST_WB;
          OP_LW, OP_SW:              w_next_state = ST_MEM;
          OP_BEQ, OP_BNE:            w_next_state = ST_FETCH;
          default:                   w_next_state = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          case (opcode)
            OP_LW:   w_next_state = ST_WB;
            OP_SW:   w_next_state = ST_FETCH;
            default: w_next_state = ST_HALT;
          endcase
        end else if (w_wait_hit) begin
          w_next_state = ST_HALT;
        end else begin
          w_next_state = ST_MEM;
        end
      end
      ST_WB:   w_next_state = ST_FETCH;
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_HALT;
    endcase
  end

  // An instruction retires whenever a post-fetch state hands back to FETCH.
  always_comb begin
    w_retire = (w_next_state == ST_FETCH) &&
               ((r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                (r_state == ST_MEM)    || (r_state == ST_WB));
  end

  // Sequencer state, wait counter, sticky flags and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_wait    <= 4'd0;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
      r_retired <= 16'd0;
    end else begin
      r_state   <= w_next_state;
      r_wait    <= (w_stall && (w_next_state == r_state)) ? (r_wait + 4'd1) : 4'd0;
      r_halted  <= r_halted | (w_next_state == ST_HALT);
      r_timeout <= r_timeout | w_wait_hit;
      r_retired <= r_retired + {15'd0, w_retire};
    end
  end

  // Strobes are forced idle for as long as reset is held.
  always_comb begin
    w_ctrl_gated = rst_n ? w_ctrl : CTRL_IDLE;
  end

  assign pc_src      = w_ctrl_gated.pc_src;
  assign pc_write    = w_ctrl_gated.pc_write;
  assign ir_write    = w_ctrl_gated.ir_write;
  assign reg_write   = w_ctrl_gated.reg_write;
  assign mem_read    = w_ctrl_gated.mem_read;
  assign mem_write   = w_ctrl_gated.mem_write;
  assign alu_src_b   = w_ctrl_gated.alu_src_b;
  assign wb_sel      = w_ctrl_gated.wb_sel;
  assign alu_op      = w_ctrl_gated.alu_op;
  assign state       = r_state;
  assign halted      = r_halted;
  assign mem_timeout = r_timeout;
  assign retired     = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process pushes the
// hand-computed per-cycle response; a monitor pops and compares each cycle.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  pc_src;
  logic        pc_write, ir_write, reg_write, mem_read, mem_write;
  logic [1:0]  alu_src_b, wb_sel, alu_op;
  logic [2:0]  state;
  logic        halted, mem_timeout;
  logic [15:0] retired;

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_src(pc_src), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src_b(alu_src_b), .wb_sel(wb_sel),
    .alu_op(alu_op), .state(state), .halted(halted), .mem_timeout(mem_timeout),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe patterns: {pc_src, pcw irw rw mr mw, alu_src_b, wb_sel, alu_op}
  localparam logic [12:0] S_IDLE = 13'b00_00000_00_00_00;
  localparam logic [12:0] F_RDY  = 13'b00_11010_01_00_00;
  localparam logic [12:0] F_NR   = 13'b00_00010_01_00_00;
  localparam logic [12:0] D_JMP  = 13'b10_10000_00_00_00;
  localparam logic [12:0] D_CALL = 13'b10_10100_00_10_00;
  localparam logic [12:0] X_IMM  = 13'b00_00000_10_00_00;
  localparam logic [12:0] X_ANDI = 13'b00_00000_10_00_10;
  localparam logic [12:0] X_RALU = 13'b00_00000_00_00_10;
  localparam logic [12:0] X_BR_T = 13'b01_10000_00_00_01;
  localparam logic [12:0] X_BR_N = 13'b01_00000_00_00_01;
  localparam logic [12:0] M_LW   = 13'b00_00010_00_00_00;
  localparam logic [12:0] M_SW   = 13'b00_00001_00_00_00;
  localparam logic [12:0] W_ALU  = 13'b00_00100_00_00_00;
  localparam logic [12:0] W_MEM  = 13'b00_00100_00_01_00;

  typedef struct {
    string       name;
    logic [33:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic stim_done = 1'b0;

  // One cycle of stimulus plus the response expected during that cycle.
  task automatic cyc(input string nm, input logic rn, input logic [3:0] op,
                     input logic z, input logic mr, input logic [2:0] es,
                     input logic [12:0] eb, input logic eh, input logic et,
                     input logic [15:0] er);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; opcode = op; zero = z; mem_ready = mr;
    e.name = nm;
    e.v    = {es, eb, eh, et, er};
    q.push_back(e);
  endtask

  task automatic fetch(input string nm, input logic [3:0] op, input logic [15:0] r);
    cyc(nm, 1'b1, op, 1'b0, 1'b1, 3'd0, F_RDY, 1'b0, 1'b0, r);
  endtask

  task automatic dec(input string nm, input logic [3:0] op, input logic [12:0] eb,
                     input logic [15:0] r);
    cyc(nm, 1'b1, op, 1'b0, 1'b1, 3'd1, eb, 1'b0, 1'b0, r);
  endtask

  // Monitor: compares the DUT outputs against the queued expectation mid-cycle.
  initial begin
    exp_t        m;
    logic [33:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        m   = q.pop_front();
        act = {state, pc_src, pc_write, ir_write, reg_write, mem_read, mem_write,
               alu_src_b, wb_sel, alu_op, halted, mem_timeout, retired};
        total++;
        if (act !== m.v) begin
          bad++;
          $display("FAIL %s: got st=%0d ctl=%b h=%b t=%b ret=%h, want st=%0d ctl=%b h=%b t=%b ret=%h",
                   m.name, act[33:31], act[30:18], act[17], act[16], act[15:0],
                   m.v[33:31], m.v[30:18], m.v[17], m.v[16], m.v[15:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; opcode = 4'd1; zero = 1'b0; mem_ready = 1'b1;
    cyc("reset", 1'b0, 4'd1, 1'b0, 1'b1, 3'd0, S_IDLE, 1'b0, 1'b0, 16'd0);

    // ADDI: 0,1,2,4 then back to FETCH with retired 1 (mem_ready ignored in WB)
    fetch("addi_f", 4'd1, 16'd0);
    dec("addi_d", 4'd1, S_IDLE, 16'd0);
    cyc("addi_x", 1'b1, 4'd1, 1'b0, 1'b1, 3'd2, X_IMM, 1'b0, 1'b0, 16'd0);
    cyc("addi_w", 1'b1, 4'd1, 1'b0, 1'b0, 3'd4, W_ALU, 1'b0, 1'b0, 16'd0);

    // LW with three stall cycles in MEM
    fetch("lw_f", 4'd3, 16'd1);
    cyc("lw_d", 1'b1, 4'd3, 1'b0, 1'b0, 3'd1, S_IDLE, 1'b0, 1'b0, 16'd1);
    cyc("lw_x", 1'b1, 4'd3, 1'b0, 1'b0, 3'd2, X_IMM, 1'b0, 1'b0, 16'd1);
    for (int i = 0; i < 3; i++)
      cyc("lw_m_wait", 1'b1, 4'd3, 1'b0, 1'b0, 3'd3, M_LW, 1'b0, 1'b0, 16'd1);
    cyc("lw_m_done", 1'b1, 4'd3, 1'b0, 1'b1, 3'd3, M_LW, 1'b0, 1'b0, 16'd1);
    cyc("lw_w", 1'b1, 4'd3, 1'b0, 1'b1, 3'd4, W_MEM, 1'b0, 1'b0, 16'd1);

    // SW: mem_write only in the completing cycle
    fetch("sw_f", 4'd4, 16'd2);
    dec("sw_d", 4'd4, S_IDLE, 16'd2);
    cyc("sw_x", 1'b1, 4'd4, 1'b0, 1'b1, 3'd2, X_IMM, 1'b0, 1'b0, 16'd2);
    cyc("sw_m_wait", 1'b1, 4'd4, 1'b0, 1'b0, 3'd3, S_IDLE, 1'b0, 1'b0, 16'd2);
    cyc("sw_m_done", 1'b1, 4'd4, 1'b0, 1'b1, 3'd3, M_SW, 1'b0, 1'b0, 16'd2);

    // Branches with both zero values
    fetch("beq1_f", 4'd5, 16'd3); dec("beq1_d", 4'd5, S_IDLE, 16'd3);
    cyc("beq_z1", 1'b1, 4'd5, 1'b1, 1'b1, 3'd2, X_BR_T, 1'b0, 1'b0, 16'd3);
    fetch("beq0_f", 4'd5, 16'd4); dec("beq0_d", 4'd5, S_IDLE, 16'd4);
    cyc("beq_z0", 1'b1, 4'd5, 1'b0, 1'b1, 3'd2, X_BR_N, 1'b0, 1'b0, 16'd4);
    fetch("bne1_f", 4'd6, 16'd5); dec("bne1_d", 4'd6, S_IDLE, 16'd5);
    cyc("bne_z1", 1'b1, 4'd6, 1'b1, 1'b1, 3'd2, X_BR_N, 1'b0, 1'b0, 16'd5);
    fetch("bne0_f", 4'd6, 16'd6); dec("bne0_d", 4'd6, S_IDLE, 16'd6);
    cyc("bne_z0", 1'b1, 4'd6, 1'b0, 1'b1, 3'd2, X_BR_T, 1'b0, 1'b0, 16'd6);

    // ANDI and R-ALU
    fetch("andi_f", 4'd2, 16'd7); dec("andi_d", 4'd2, S_IDLE, 16'd7);
    cyc("andi_x", 1'b1, 4'd2, 1'b0, 1'b1, 3'd2, X_ANDI, 1'b0, 1'b0, 16'd7);
    cyc("andi_w", 1'b1, 4'd2, 1'b0, 1'b1, 3'd4, W_ALU, 1'b0, 1'b0, 16'd7);
    fetch("ralu_f", 4'd0, 16'd8); dec("ralu_d", 4'd0, S_IDLE, 16'd8);
    cyc("ralu_x", 1'b1, 4'd0, 1'b0, 1'b1, 3'd2, X_RALU, 1'b0, 1'b0, 16'd8);
    cyc("ralu_w", 1'b1, 4'd0, 1'b0, 1'b1, 3'd4, W_ALU, 1'b0, 1'b0, 16'd8);

    // JMP, RET, CALL complete in DECODE
    fetch("jmp_f", 4'd7, 16'd9);   dec("jmp_d", 4'd7, D_JMP, 16'd9);
    fetch("ret_f", 4'd9, 16'd10);  dec("ret_d", 4'd9, D_JMP, 16'd10);
    fetch("call_f", 4'd8, 16'd11); dec("call_d", 4'd8, D_CALL, 16'd11);

    // 14 stall cycles in FETCH stay below the watchdog limit
    for (int i = 0; i < 14; i++)
      cyc("fetch_stall14", 1'b1, 4'd1, 1'b0, 1'b0, 3'd0, F_NR, 1'b0, 1'b0, 16'd12);
    fetch("stall_f", 4'd1, 16'd12);
    dec("stall_d", 4'd1, S_IDLE, 16'd12);
    cyc("stall_x", 1'b1, 4'd1, 1'b0, 1'b1, 3'd2, X_IMM, 1'b0, 1'b0, 16'd12);
    cyc("stall_w", 1'b1, 4'd1, 1'b0, 1'b1, 3'd4, W_ALU, 1'b0, 1'b0, 16'd12);

    // Illegal opcode 12 -> HALT, retired unchanged, HALT ignores mem_ready
    fetch("ill_f", 4'd12, 16'd13);
    dec("ill_d", 4'd12, S_IDLE, 16'd13);
    for (int i = 0; i < 3; i++)
      cyc("halt_hold", 1'b1, 4'd12, 1'b0, 1'b1, 3'd5, S_IDLE, 1'b1, 1'b0, 16'd13);
    cyc("rst_from_halt", 1'b0, 4'd1, 1'b0, 1'b1, 3'd0, S_IDLE, 1'b0, 1'b0, 16'd0);

    // 15 stall cycles in FETCH trip the watchdog
    for (int i = 0; i < 15; i++)
      cyc("to_stall", 1'b1, 4'd1, 1'b0, 1'b0, 3'd0, F_NR, 1'b0, 1'b0, 16'd0);
    cyc("to_halt", 1'b1, 4'd1, 1'b0, 1'b1, 3'd5, S_IDLE, 1'b1, 1'b1, 16'd0);
    cyc("to_hold", 1'b1, 4'd1, 1'b0, 1'b1, 3'd5, S_IDLE, 1'b1, 1'b1, 16'd0);
    cyc("rst_from_to", 1'b0, 4'd1, 1'b0, 1'b1, 3'd0, S_IDLE, 1'b0, 1'b0, 16'd0);

    // Reset asserted mid-MEM of a store: no write strobe, counters cleared
    fetch("pre_f", 4'd1, 16'd0); dec("pre_d", 4'd1, S_IDLE, 16'd0);
    cyc("pre_x", 1'b1, 4'd1, 1'b0, 1'b1, 3'd2, X_IMM, 1'b0, 1'b0, 16'd0);
    cyc("pre_w", 1'b1, 4'd1, 1'b0, 1'b1, 3'd4, W_ALU, 1'b0, 1'b0, 16'd0);
    fetch("sw2_f", 4'd4, 16'd1); dec("sw2_d", 4'd4, S_IDLE, 16'd1);
    cyc("sw2_x", 1'b1, 4'd4, 1'b0, 1'b1, 3'd2, X_IMM, 1'b0, 1'b0, 16'd1);
    cyc("sw2_m", 1'b1, 4'd4, 1'b0, 1'b0, 3'd3, S_IDLE, 1'b0, 1'b0, 16'd1);
    cyc("rst_mid_mem", 1'b0, 4'd4, 1'b0, 1'b1, 3'd0, S_IDLE, 1'b0, 1'b0, 16'd0);
    cyc("post_rst_f", 1'b1, 4'd4, 1'b0, 1'b0, 3'd0, F_NR, 1'b0, 1'b0, 16'd0);

    // Stand-in for 65535 retirements: load the counter while FETCH stalls
    @(negedge clk);
    #1 force dut.r_retired = 16'hFFFF;
    @(posedge clk);
    #1 release dut.r_retired;
    fetch("wrap_f", 4'd1, 16'hFFFF);
    dec("wrap_d", 4'd1, S_IDLE, 16'hFFFF);
    cyc("wrap_x", 1'b1, 4'd1, 1'b0, 1'b1, 3'd2, X_IMM, 1'b0, 1'b0, 16'hFFFF);
    cyc("wrap_w", 1'b1, 4'd1, 1'b0, 1'b1, 3'd4, W_ALU, 1'b0, 1'b0, 16'hFFFF);
    fetch("wrap_done", 4'd1, 16'h0000);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
